// File: rtl/multi_buffer_memory.sv
// multi_buffer_memory
// Single-clock N-bank frame buffer between a producer and a consumer.
// The producer fills the write bank (W) and commits it, making it the pending
// bank (P). The consumer reads the read bank (R) and swaps to P at its frame
// boundary. BANKS=2 gives a stalling double buffer; BANKS>=3 never stalls the
// producer and counts committed frames that were overwritten before display.
//
// Parameters: A (address bits per bank), S (data width), BANKS (2..4),
//             CW (drop counter width).
// Ports:
//   clock, reset_reset         : clock, asynchronous active-low reset
//   address_write, data_write,
//   wren, commit               : producer side
//   address_read, data_read,
//   swap                       : consumer side (data_read is registered)
//   write_ready, pending,
//   underrun, drop_count       : flow status
//   rd_bank, wr_bank           : current bank indices (debug)
module multi_buffer_memory #(
    parameter int A     = 9,
    parameter int S     = 24,
    parameter int BANKS = 3,
    parameter int CW    = 8
) (
    input  logic          clock,
    input  logic          reset_reset,
    input  logic [A-1:0]  address_write,
    input  logic [S-1:0]  data_write,
    input  logic          wren,
    input  logic          commit,
    input  logic [A-1:0]  address_read,
    output logic [S-1:0]  data_read,
    input  logic          swap,
    output logic          write_ready,
    output logic          pending,
    output logic          underrun,
    output logic [CW-1:0] drop_count,
    output logic [1:0]    rd_bank,
    output logic [1:0]    wr_bank
);

    // Bank select bits actually used in the physical address.
    localparam int BW    = (BANKS > 2) ? 2 : 1;
    localparam int DEPTH = BANKS << A;

    logic [S-1:0] mem [DEPTH];

    logic [1:0]    p_bank;
    logic          p_valid;

    logic [1:0]    rd_next;
    logic [1:0]    wr_next;
    logic [1:0]    p_next;
    logic          pv_next;
    logic          ready_next;
    logic          underrun_next;
    logic [CW-1:0] drop_next;
    logic          swap_hit;

    // Lowest-index bank that is neither a nor b; fallback when none exists
    // (only possible with two banks, where W simply parks on P while stalled).
    function automatic logic [1:0] lowest_free(input logic [1:0] a,
                                               input logic [1:0] b,
                                               input logic [1:0] fallback);
        logic [1:0] res;
        res = fallback;
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (2'(i) != a && 2'(i) != b) res = 2'(i);
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    // Role update: swap is resolved first against the registered roles, then
    // commit is applied on top of the post-swap roles.
    always_comb begin
        rd_next       = rd_bank;
        wr_next       = wr_bank;
        p_next        = p_bank;
        pv_next       = p_valid;
        underrun_next = 1'b0;
        drop_next     = drop_count;
        swap_hit      = 1'b0;

        if (swap) begin
            if (p_valid) begin
                swap_hit = 1'b1;
                rd_next  = p_bank;
                pv_next  = 1'b0;
                // With two banks the freed read bank is the only place to write.
                if (BANKS == 2) wr_next = rd_bank;
            end else begin
                underrun_next = 1'b1;
            end
        end

        if (commit && write_ready) begin
            // A pending frame still present after the swap is lost.
            if (pv_next) drop_next = sat_inc(drop_count);
            p_next  = wr_next;
            pv_next = 1'b1;
            // Swap+commit rotates: the old read bank becomes the write bank.
            if (swap_hit) wr_next = rd_bank;
            else          wr_next = lowest_free(rd_next, p_next, wr_next);
        end

        ready_next = (BANKS == 2) ? !pv_next : 1'b1;
    end

    always_ff @(posedge clock or negedge reset_reset) begin
        if (!reset_reset) begin
            rd_bank     <= 2'd1;
            wr_bank     <= 2'd0;
            p_bank      <= 2'd0;
            p_valid     <= 1'b0;
            write_ready <= 1'b1;
            underrun    <= 1'b0;
            drop_count  <= '0;
        end else begin
            rd_bank     <= rd_next;
            wr_bank     <= wr_next;
            p_bank      <= p_next;
            p_valid     <= pv_next;
            write_ready <= ready_next;
            underrun    <= underrun_next;
            drop_count  <= drop_next;
        end
    end

    assign pending = p_valid;

    // Storage port: writes go to the pre-edge write bank, so a write coinciding
    // with a commit lands in the frame being committed.
    always_ff @(posedge clock) begin
        if (wren && write_ready) mem[{wr_bank[BW-1:0], address_write}] <= data_write;
    end

    // Read stage: uses the pre-edge read bank, one cycle of latency.
    always_ff @(posedge clock or negedge reset_reset) begin
        if (!reset_reset) data_read <= '0;
        else              data_read <= mem[{rd_bank[BW-1:0], address_read}];
    end

endmodule
